// File: rtl/classify_accum_pipe3.sv
// Per-centroid coordinate accumulator (k-means stage 3).
// Sums each classified point into its centroid's per-coordinate accumulators
// and counts points per centroid, with saturation and sticky error flags.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   clear             - start of iteration: zero all sums/counts/flags, enter ACCUM
//   valid_in, last_in - point/index beat valid, final beat of the iteration
//   index             - classified centroid, 1..centroid_num
//   point_from_pipe2  - packed point, coordinate k at [13k+12:13k]
//   rd_en, rd_addr    - read request for centroid rd_addr+1
//   rd_accum, rd_count, rd_valid - registered read data, one cycle after rd_en
//   busy, done        - in ACCUM; one-cycle pulse on entering DONE
//   ovf, idx_err      - sticky saturation / illegal-index flags
module classify_accum_pipe3 #(
   parameter int unsigned dataWidth        = 91,
   parameter int unsigned cordinate_width  = 13,
   parameter int unsigned accum_cord_width = 22,
   parameter int unsigned accum_width      = 7 * 22,
   parameter int unsigned centroid_num     = 8,
   parameter int unsigned count_width      = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   valid_in,
   input  logic                   last_in,
   input  logic [3:0]             index,
   input  logic [dataWidth-1:0]   point_from_pipe2,
   input  logic                   rd_en,
   input  logic [2:0]             rd_addr,
   output logic [accum_width-1:0] rd_accum,
   output logic [count_width-1:0] rd_count,
   output logic                   rd_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   ovf,
   output logic                   idx_err
);

   localparam int unsigned NUM_COORD = dataWidth / cordinate_width;
   localparam int unsigned SUM_W     = accum_cord_width + 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t state, next_state;
   logic   busy_d, done_d;

   logic [accum_cord_width-1:0] acc [centroid_num][NUM_COORD];
   logic [count_width-1:0]      cnt [centroid_num];

   logic                        beat, idx_ok, cnt_full, sat_any;
   logic [2:0]                  sel;
   logic [SUM_W-1:0]            sum     [NUM_COORD];
   logic [accum_cord_width-1:0] acc_upd [NUM_COORD];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next state; clear overrides everything, including a concurrent last beat
   always_comb begin
      next_state = state;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      if (clear)
         next_state = ACCUM;
      else if (state == ACCUM && valid_in && last_in)
         next_state = DONE;
      busy_d = (next_state == ACCUM);
      done_d = (next_state == DONE) && (state != DONE);
   end

   // Saturating per-coordinate add for the addressed centroid
   always_comb begin
      beat     = valid_in && !clear && (state == ACCUM);
      idx_ok   = (index != 4'd0) && (index <= 4'(centroid_num));
      sel      = 3'(index - 4'd1);
      cnt_full = (cnt[sel] == {count_width{1'b1}});
      sat_any  = 1'b0;
      for (int unsigned k = 0; k < NUM_COORD; k++) begin
         sum[k] = SUM_W'(acc[sel][k])
                + SUM_W'(point_from_pipe2[k*cordinate_width +: cordinate_width]);
         if (sum[k][SUM_W-1]) begin
            acc_upd[k] = {accum_cord_width{1'b1}};
            sat_any    = 1'b1;
         end else begin
            acc_upd[k] = sum[k][accum_cord_width-1:0];
         end
      end
   end

   // Status outputs and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         idx_err <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
         if (clear) begin
            ovf     <= 1'b0;
            idx_err <= 1'b0;
         end else if (beat) begin
            if (!idx_ok)                   idx_err <= 1'b1;
            else if (cnt_full || sat_any) ovf     <= 1'b1;
         end
      end
   end

   // Accumulators and counts; a full count freezes that point's sums too
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < centroid_num; c++) begin
            cnt[c] <= '0;
            for (int unsigned k = 0; k < NUM_COORD; k++) acc[c][k] <= '0;
         end
      end else if (clear) begin
         for (int unsigned c = 0; c < centroid_num; c++) begin
            cnt[c] <= '0;
            for (int unsigned k = 0; k < NUM_COORD; k++) acc[c][k] <= '0;
         end
      end else if (beat && idx_ok && !cnt_full) begin
         cnt[sel] <= cnt[sel] + 1'b1;
         for (int unsigned k = 0; k < NUM_COORD; k++) acc[sel][k] <= acc_upd[k];
      end
   end

   // Read port; samples pre-update contents when colliding with a beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_count <= '0;
         rd_accum <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_count <= cnt[rd_addr];
            for (int unsigned k = 0; k < NUM_COORD; k++)
               rd_accum[k*accum_cord_width +: accum_cord_width] <= acc[rd_addr][k];
         end
      end
   end

endmodule

// File: tb/tb_classify_accum_pipe3.sv
// Self-checking bench for classify_accum_pipe3: read expectations are queued
// when a read is issued and compared when rd_valid comes back.
module tb_classify_accum_pipe3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear = 1'b0, valid_in = 1'b0, last_in = 1'b0, rd_en = 1'b0;
   logic [3:0]   index = '0;
   logic [90:0]  point = '0;
   logic [2:0]   rd_addr = '0;
   logic [153:0] rd_accum;
   logic [9:0]   rd_count;
   logic         rd_valid, busy, done, ovf, idx_err;

   typedef struct {
      logic [153:0] acc;
      logic [9:0]   cnt;
   } rd_exp_t;

   rd_exp_t rd_q[$];
   rd_exp_t e;
   int      n_cmp = 0, n_bad = 0, done_cnt = 0, d0;
   logic    en_q;

   classify_accum_pipe3 dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
      .last_in(last_in), .index(index), .point_from_pipe2(point),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_accum(rd_accum),
      .rd_count(rd_count), .rd_valid(rd_valid), .busy(busy), .done(done),
      .ovf(ovf), .idx_err(idx_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [90:0] mp(input int unsigned v, input bit only0);
      logic [90:0] r = '0;
      for (int k = 0; k < 7; k++) if (!only0 || k == 0) r[k*13 +: 13] = 13'(v);
      return r;
   endfunction

   function automatic logic [153:0] pk(input int unsigned v, input bit only0);
      logic [153:0] r = '0;
      for (int k = 0; k < 7; k++) if (!only0 || k == 0) r[k*22 +: 22] = 22'(v);
      return r;
   endfunction

   // Advance one cycle, then return all inputs to idle
   task automatic cyc();
      @(negedge clk);
      clear = 1'b0; valid_in = 1'b0; last_in = 1'b0; rd_en = 1'b0;
      index = '0; point = '0;
   endtask

   task automatic set_beat(input int idx, input logic [90:0] pt, input bit last);
      valid_in = 1'b1; index = 4'(idx); point = pt; last_in = last;
   endtask

   task automatic set_rd(input int addr, input logic [153:0] acc, input int cnt);
      rd_en = 1'b1; rd_addr = 3'(addr);
      rd_q.push_back('{acc, 10'(cnt)});
   endtask

   // Read-response monitor and done-pulse counter
   always @(posedge clk) begin
      en_q = rd_en;
      #2;
      if (en_q || rd_valid) begin
         check("rd_valid", rd_valid, en_q);
         if (en_q) begin
            check("rd_queue_nonempty", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) begin
               e = rd_q.pop_front();
               check("rd_accum", rd_accum, e.acc);
               check("rd_count", rd_count, e.cnt);
            end
         end
      end
      if (done) done_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);   check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);     check("rst_idx_err", idx_err, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_count", rd_count, 0); check("rst_rd_accum", rd_accum, 0);
      rst_n = 1'b1;
      set_rd(5, '0, 0); cyc(); cyc();
      check("idle_busy", busy, 0);

      // Three beats to centroid 3, reads collide with updates
      clear = 1'b1; cyc();
      check("t1_busy_hi", busy, 1);
      d0 = done_cnt;
      set_beat(3, mp(5, 0), 0); set_rd(2, '0, 0); cyc();
      set_beat(3, mp(5, 0), 0); set_rd(2, pk(5, 0), 1); cyc();
      set_beat(3, mp(5, 0), 1); cyc();
      check("t1_done_hi", done, 1); check("t1_busy_lo", busy, 0);
      set_rd(2, pk(15, 0), 3); cyc();
      check("t1_done_lo", done, 0);
      cyc();
      check("t1_done_once", done_cnt - d0, 1);

      // One beat to each centroid, then read all back-to-back
      clear = 1'b1; cyc();
      for (int i = 1; i <= 8; i++) begin
         set_beat(i, mp(i, 0), i == 8); cyc();
      end
      for (int i = 1; i <= 8; i++) begin
         set_rd(i - 1, pk(i, 0), 1); cyc();
      end
      cyc();
      check("t2_ovf", ovf, 0); check("t2_idx_err", idx_err, 0); check("t2_busy", busy, 0);

      // Coordinate saturation: 513th beat of 8191 crosses 2^22-1
      clear = 1'b1; cyc();
      for (int i = 0; i < 600; i++) begin
         if (i == 512) check("t3_ovf_pre", ovf, 0);
         if (i == 514) check("t3_ovf_set", ovf, 1);
         set_beat(1, mp(8191, 1), 0); cyc();
      end
      check("t3_ovf", ovf, 1); check("t3_busy", busy, 1);
      set_rd(0, pk(4194303, 1), 600); cyc(); cyc();

      // Count saturation: 1024th point is dropped
      clear = 1'b1; cyc();
      check("t4_ovf_cleared", ovf, 0);
      for (int i = 0; i < 1024; i++) begin
         if (i == 1023) check("t4_ovf_pre", ovf, 0);
         set_beat(4, mp(1, 0), 0); cyc();
      end
      check("t4_ovf", ovf, 1);
      set_rd(3, pk(1023, 0), 1023); cyc(); cyc();

      // Illegal indices, last on an illegal beat, then input in DONE
      clear = 1'b1; cyc();
      check("t5_ovf_cleared", ovf, 0);
      d0 = done_cnt;
      set_beat(0, mp(9, 0), 0); cyc();
      check("t5_idx_err", idx_err, 1);
      set_beat(9, mp(9, 0), 1); cyc();
      check("t5_busy", busy, 0); check("t5_done", done, 1);
      set_beat(1, mp(3, 0), 0); cyc();
      check("t5_idx_err_hold", idx_err, 1);
      set_rd(0, '0, 0); cyc();
      set_rd(3, '0, 0); cyc(); cyc();
      check("t5_done_once", done_cnt - d0, 1);

      // clear wins over a concurrent beat; beats in DONE ignored
      clear = 1'b1; cyc();
      clear = 1'b1; set_beat(2, mp(4, 0), 0); cyc();
      set_beat(5, mp(7, 0), 1); cyc();
      set_beat(2, mp(4, 0), 1); cyc();
      set_rd(1, '0, 0); cyc();
      set_rd(4, pk(7, 0), 1); cyc(); cyc();
      check("t6_idx_err", idx_err, 0); check("t6_ovf", ovf, 0); check("t6_busy", busy, 0);

      // Asynchronous reset mid-ACCUM
      clear = 1'b1; cyc();
      set_beat(6, mp(2, 0), 0); cyc();
      set_beat(6, mp(2, 0), 0); cyc();
      set_rd(5, pk(4, 0), 2); cyc();
      set_beat(6, mp(2, 0), 0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);   check("arst_done", done, 0);
      check("arst_ovf", ovf, 0);     check("arst_idx_err", idx_err, 0);
      check("arst_rd_valid", rd_valid, 0);
      check("arst_rd_count", rd_count, 0); check("arst_rd_accum", rd_accum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      check("post_rst_busy", busy, 0);
      set_rd(5, '0, 0); cyc(); cyc();
      check("post_rst_idle", busy, 0);
      clear = 1'b1; cyc();
      check("post_rst_clear_busy", busy, 1);

      repeat (3) cyc();
      check("rd_pending", rd_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/classify_accum_pipe3.md
CLASSIFY_ACCUM_PIPE3 -- requirements
Module: classify_accum_pipe3

Interface
REQ-001 SHALL have parameter dataWidth, default 91, meaning packed point width (7 coordinates).
REQ-002 SHALL have parameter cordinate_width, default 13, meaning unsigned coordinate width.
REQ-003 SHALL have parameter accum_cord_width, default 22, meaning per-coordinate accumulator width.
REQ-004 SHALL have parameter accum_width, default 7*22, meaning packed accumulator width per centroid.
REQ-005 SHALL have parameter centroid_num, default 8, meaning number of centroids.
REQ-006 SHALL have parameter count_width, default 10, meaning per-centroid point-count width.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port clear, input, 1, start-of-iteration pulse.
REQ-010 SHALL have port valid_in, input, 1, point/index pair valid this cycle.
REQ-011 SHALL have port last_in, input, 1, qualifies the final point of the iteration (meaningful only with valid_in).
REQ-012 SHALL have port index, input, 4, classified centroid, legal values 1..8.
REQ-013 SHALL have port point_from_pipe2, input, dataWidth, point aligned with index; coordinate k occupies bits [13k+12:13k].
REQ-014 SHALL have port rd_en, input, 1, read request.
REQ-015 SHALL have port rd_addr, input, 3, centroid to read (0 means centroid 1).
REQ-016 SHALL have port rd_accum, output, accum_width, registered coordinate sums; coordinate k occupies bits [22k+21:22k].
REQ-017 SHALL have port rd_count, output, count_width, registered point count.
REQ-018 SHALL have port rd_valid, output, 1, rd_accum/rd_count valid.
REQ-019 SHALL have port busy, output, 1, high in ACCUM state.
REQ-020 SHALL have port done, output, 1, one-cycle pulse on entering DONE.
REQ-021 SHALL have port ovf, output, 1, sticky saturation flag.
REQ-022 SHALL have port idx_err, output, 1, sticky illegal-index flag.

Function
REQ-023 FSM states SHALL be IDLE, ACCUM, DONE; clear from any state -> ACCUM; ACCUM with valid_in&last_in -> DONE; DONE holds until clear.
REQ-024 clear SHALL zero all 8 accumulators, all 8 counts, ovf and idx_err in the same edge.
REQ-025 In ACCUM, valid_in with index n in 1..8 SHALL add each 13-bit coordinate (zero-extended) to accumulator n coordinate k and increment count n, visible on the next edge.
REQ-026 Per-coordinate sum exceeding 2^22-1 SHALL saturate at 2^22-1 and set ovf.
REQ-027 count at 1023 receiving a further point SHALL remain 1023, set ovf, and leave that point's sums unchanged.
REQ-028 index 0 or 9..15 with valid_in in ACCUM SHALL leave all state unchanged and set idx_err; last_in on such a beat SHALL still transition to DONE.
REQ-029 valid_in in IDLE or DONE SHALL be ignored (no state change, no flag).
REQ-030 clear and valid_in in the same cycle: clear SHALL win and the beat SHALL be discarded.
REQ-031 done SHALL be high exactly one cycle, on the first DONE cycle; busy SHALL be high iff the state is ACCUM.
REQ-032 Read: rd_en at edge t SHALL present rd_accum/rd_count of centroid rd_addr+1 and rd_valid=1 after edge t+1; rd_valid SHALL be 0 in cycles without a prior-cycle rd_en.
REQ-033 Read during an update of the same centroid in the same cycle SHALL return the pre-update value.
REQ-034 Back-to-back valid_in on every cycle, including to the same centroid, SHALL be accepted without loss (throughput 1 point/cycle).

Reset
REQ-035 rst_n low SHALL asynchronously force state IDLE, zero all accumulators and counts, and zero rd_accum, rd_count, rd_valid, busy, done, ovf and idx_err.
REQ-036 rst_n asserted mid-ACCUM SHALL discard the partial iteration; after release the block SHALL stay IDLE until clear.

Verification
REQ-037 Reset, clear, valid_in with index=3 and all coordinates=5, three cycles back-to-back, last_in on the third; read rd_addr=2 -> each coordinate of rd_accum=15, rd_count=3, done pulsed once, busy=0.
REQ-038 Clear, 8 beats with index 1..8 and point coordinates all equal to i; read every centroid -> centroid i sums=i, count=1, ovf=0, idx_err=0.
REQ-039 Clear, 600 beats to index 1 with coordinate 0 = 8191 -> sum saturates at 4194303, ovf=1, count=600.
REQ-040 Clear, beat with index=0, then beat with index=9 plus last_in -> no sums/counts change, idx_err=1, state DONE.
REQ-041 clear asserted together with valid_in (index=2) -> count 2 = 0 afterwards; then valid_in during DONE is ignored.
REQ-042 rst_n dropped asynchronously mid-ACCUM, between clock edges -> all outputs 0 immediately; a valid_in after release leaves state unchanged until clear.
